fir_out_requant: RTL and testbench
==================================

Name: fir_out_requant

Overview:
Downstream stage of the FIR core. It consumes the 32-bit signed AXI-Stream output (sm_*) and re-quantises each sample to pOUT_WIDTH bits, using a programmable arithmetic right shift with round-half-up and optional saturation. Results are buffered in a small FIFO and re-emitted as AXI-Stream toward the DMA/sink. The block also tracks frame boundaries (tlast) and reports per-frame beat and saturation counts.

Parameters:
- pDATA_WIDTH, 32, input sample width (signed)
- pOUT_WIDTH, 16, output sample width (signed)
- pFIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
- pSHIFT_WIDTH, 5, width of cfg_shift

Ports:
- axis_clk  in  1  clock
- axis_rst  in  1  synchronous active-high reset
- cfg_shift  in  pSHIFT_WIDTH  right-shift amount, 0..31
- cfg_sat_en  in  1  1 = clamp to output range, 0 = keep low pOUT_WIDTH bits
- s_tvalid  in  1  from FIR sm_tvalid
- s_tdata  in  pDATA_WIDTH  from FIR sm_tdata
- s_tlast  in  1  from FIR sm_tlast
- s_tready  out  1  to FIR sm_tready
- m_tvalid  out  1  output stream valid
- m_tdata  out  pOUT_WIDTH  re-quantised sample
- m_tlast  out  1  end of frame
- m_tready  in  1  output stream ready
- busy  out  1  frame in progress (state != IDLE)
- frame_done  out  1  one-cycle pulse when a frame fully drains
- frame_beats  out  16  beats in the last completed frame
- sat_cnt  out  16  clamp events in the last completed frame

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, frame_done=0, frame_beats=0, sat_cnt=0.
  - FIFO empty, pipeline stage invalid, FSM in IDLE.
- FSM, states IDLE, RUN, FLUSH:
  - IDLE -> RUN on the first accepted beat. cfg_shift and cfg_sat_en are captured on that beat and held for the whole frame. The working beat/sat counters clear to 0, then count that beat.
  - RUN -> FLUSH when the accepted beat has s_tlast=1.
  - FLUSH -> IDLE when the FIFO is empty, the stage is invalid and no pop is pending. On that transition: frame_done pulses for 1 cycle, and frame_beats/sat_cnt load from the working counters.
  - A tlast on the very first beat goes IDLE -> FLUSH directly.
- Acceptance:
  - s_tready = (state != FLUSH) && (fifo_count + stage_valid < pFIFO_DEPTH). It is a credit check, so it never depends on m_tready combinationally.
  - A beat is accepted when s_tvalid && s_tready.
  - In IDLE with space available, s_tready=1.
- Arithmetic (combinational on s_tdata, 33-bit signed):
  - shift=0: r = x.
  - shift>0: r = (x + 2^(shift-1)) >>> shift.
  - Saturation with sat_en=1: r > 2^(pOUT_WIDTH-1)-1 gives 0x7FFF; r < -2^(pOUT_WIDTH-1) gives 0x8000; each clamp increments the working sat counter.
  - With sat_en=0: output r[pOUT_WIDTH-1:0] and do not count.
- Pipeline: the accepted beat loads the stage register (data, last, sat flag). The next cycle pushes it into the FIFO.
- Latency: a beat accepted at edge k is seen as m_tvalid=1 after edge k+2 if the FIFO was empty.
- Output: m_tvalid = !fifo_empty; m_tdata/m_tlast are the FIFO head, registered. Pop on m_tvalid && m_tready.
- Simultaneous push and pop: count unchanged, order preserved. Overflow is impossible by the credit rule. Underflow is impossible because pop requires m_tvalid.
- The working counters saturate at 0xFFFF (no wrap).
- Reset mid-frame discards FIFO contents and the stage, and returns to IDLE. There is no frame_done pulse.
- m_tdata/m_tlast are stable while m_tvalid && !m_tready.

Decomposition:
- Shared package fir_pkg: FSM state encoding (IDLE/RUN/FLUSH), the output min/max constants, and the rounding helper function.
- One natural sub-module, fir_sync_fifo: parameterised synchronous FIFO with push/pop/count/empty/full and active-high sync reset.
- Requant arithmetic and the FSM stay in the top module.

Test Plan:
- Rounding: shift=4, sat_en=1.
  - Input 0x00000128 -> m_tdata 0x0013.
  - Input 0xFFFFFFE8 (-24) -> 0xFFFF.
  - Input 0xFFFFFFF8 (-8) -> 0x0000.
- Saturation: shift=0, input 0x00100000.
  - sat_en=1 -> 0x7FFF; after tlast, sat_cnt=1.
  - sat_en=0 -> 0x0000; sat_cnt=0.
  - Input 0x80000000 with sat_en=1 -> 0x8000.
- Backpressure: m_tready=0, 6 beats offered with DEPTH=4.
  - s_tready drops after exactly 4 accepts.
  - Then m_tready=1: all 6 emerge in order, no duplicates or gaps.
- Frame end: 3-beat frame with tlast on beat 3, m_tready toggling 1,0,1.
  - m_tlast on output 3 only.
  - s_tready=0 throughout FLUSH.
  - frame_done pulses once after the last pop; frame_beats=3.
  - A new frame is then accepted, using the newly captured cfg_shift.
- Latency: single beat into an idle block with m_tready=1 -> m_tvalid rises 2 cycles after the accept edge.
- Reset mid-frame: axis_rst asserted after 2 beats with the FIFO non-empty.
  - Next cycle: m_tvalid=0, s_tready=0, busy=0, no frame_done.
  - After release, a fresh 1-beat frame reports frame_beats=1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output re-quantiser: frame FSM encoding,
// output range limits and the round-half-up arithmetic shift helper.
package fir_pkg;

    // Frame tracking states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Internal arithmetic width: one guard bit above the 32-bit input so the
    // rounding bias can never overflow.
    localparam int ACC_W = 33;

    // Clamp limits for the default 16-bit output
    localparam int                      OUT_W_DEFAULT   = 16;
    localparam logic signed [ACC_W-1:0] OUT_MAX_DEFAULT = 33'sd32767;
    localparam logic signed [ACC_W-1:0] OUT_MIN_DEFAULT = -33'sd32768;

    // Largest signed value representable in w bits
    function automatic logic signed [ACC_W-1:0] out_max(input int unsigned w);
        logic signed [ACC_W-1:0] one;
        one = 1;
        return (one <<< (w - 1)) - one;
    endfunction

    // Smallest signed value representable in w bits
    function automatic logic signed [ACC_W-1:0] out_min(input int unsigned w);
        logic signed [ACC_W-1:0] one;
        one = 1;
        return -(one <<< (w - 1));
    endfunction

    // Arithmetic right shift with round-half-up; shift of zero passes through
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] x,
        input logic        [7:0]       sh
    );
        logic signed [ACC_W-1:0] one;
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] sum;
        one  = 1;
        bias = '0;
        if (sh != 8'd0) begin
            bias = one <<< (sh - 8'd1);
        end
        sum = x + bias;
        return sum >>> sh;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with a registered head. Entries live in an inferred RAM
// array; the head register is refilled from the array one cycle after a
// write, so a word written into an empty FIFO is visible two edges after it
// was presented. count includes the word held in the head register.
module fir_sync_fifo #(
    parameter int pWIDTH = 17,
    parameter int pDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic [pWIDTH-1:0]         din,
    input  logic                      pop,
    output logic [pWIDTH-1:0]         dout,
    output logic                      valid,
    output logic [$clog2(pDEPTH):0]   count,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;

    logic [pWIDTH-1:0] mem_q [pDEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     mem_cnt_q;
    logic [CW-1:0]     mem_cnt_d;
    logic              head_valid_q;
    logic              head_valid_d;
    logic [pWIDTH-1:0] head_q;
    logic              load_head;

    // Refill the head whenever it is empty or being consumed this cycle
    assign load_head = (mem_cnt_q != '0) && (!head_valid_q || pop);

    // Next-state for the array occupancy and head flag
    always_comb begin
        mem_cnt_d    = mem_cnt_q + CW'(push) - CW'(load_head);
        head_valid_d = head_valid_q;
        if (load_head) begin
            head_valid_d = 1'b1;
        end else if (pop) begin
            head_valid_d = 1'b0;
        end
    end

    // RAM write port (no reset so it maps onto block/distributed RAM)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy and the registered head read
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load_head) begin
                head_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            mem_cnt_q    <= mem_cnt_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign dout  = head_q;
    assign valid = head_valid_q;
    assign count = mem_cnt_q + CW'(head_valid_q);
    assign empty = (count == '0);
    assign full  = (count >= CW'(pDEPTH));

endmodule

// File: rtl/fir_out_requant.sv
// Output re-quantiser for the FIR core. Each accepted 32-bit sample is
// rounded (half-up) by a per-frame right shift, optionally clamped to the
// output range, staged for one cycle and pushed into a small FIFO that feeds
// the outgoing AXI-Stream. A frame FSM captures the configuration on the
// first beat, blocks input while the frame drains and reports per-frame beat
// and clamp counts.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH  = 32,
    parameter int pOUT_WIDTH   = 16,
    parameter int pFIFO_DEPTH  = 4,
    parameter int pSHIFT_WIDTH = 5
) (
    input  logic                    axis_clk,
    input  logic                    axis_rst,
    input  logic [pSHIFT_WIDTH-1:0] cfg_shift,
    input  logic                    cfg_sat_en,
    input  logic                    s_tvalid,
    input  logic [pDATA_WIDTH-1:0]  s_tdata,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic                    m_tvalid,
    output logic [pOUT_WIDTH-1:0]   m_tdata,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic                    busy,
    output logic                    frame_done,
    output logic [15:0]             frame_beats,
    output logic [15:0]             sat_cnt
);

    localparam int CW = $clog2(pFIFO_DEPTH) + 1;
    localparam logic signed [ACC_W-1:0] OUT_MAX = out_max(pOUT_WIDTH);
    localparam logic signed [ACC_W-1:0] OUT_MIN = out_min(pOUT_WIDTH);

    // Frame FSM and captured configuration
    state_t                  state_q;
    logic [pSHIFT_WIDTH-1:0] cfg_shift_q;
    logic                    cfg_sat_en_q;

    // Working and reported counters
    logic [15:0] beat_work_q;
    logic [15:0] sat_work_q;
    logic [15:0] frame_beats_q;
    logic [15:0] sat_cnt_q;
    logic        frame_done_q;

    // One-deep stage between the arithmetic and the FIFO
    logic                  stage_valid_q;
    logic [pOUT_WIDTH-1:0] stage_data_q;
    logic                  stage_last_q;
    logic                  stage_sat_q;

    // FIFO interface
    logic [pOUT_WIDTH:0]   fifo_dout;
    logic                  fifo_valid;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Handshake and arithmetic nets
    logic                    credit_ok;
    logic                    accept;
    logic                    pop;
    logic                    drain_done;
    logic [pSHIFT_WIDTH-1:0] shift_eff;
    logic                    sat_en_eff;
    logic signed [ACC_W-1:0] rounded;
    logic [pOUT_WIDTH-1:0]   req_data;
    logic                    req_sat;

    // Credit check: stage plus FIFO occupancy must leave room for one more
    assign credit_ok  = ((fifo_count + CW'(stage_valid_q)) < CW'(pFIFO_DEPTH)) && !fifo_full;
    assign s_tready   = !axis_rst && (state_q != S_FLUSH) && credit_ok;
    assign accept     = s_tvalid && s_tready;
    assign pop        = fifo_valid && m_tready;
    assign drain_done = (state_q == S_FLUSH) && fifo_empty && !stage_valid_q && !pop;

    // The first beat of a frame uses the live configuration; later beats use
    // the copy captured on that first beat.
    assign shift_eff  = (state_q == S_IDLE) ? cfg_shift  : cfg_shift_q;
    assign sat_en_eff = (state_q == S_IDLE) ? cfg_sat_en : cfg_sat_en_q;
    assign rounded    = round_shift(ACC_W'(signed'(s_tdata)), 8'(shift_eff));

    // Clamp or truncate the rounded value to the output width
    always_comb begin
        req_data = rounded[pOUT_WIDTH-1:0];
        req_sat  = 1'b0;
        if (sat_en_eff) begin
            if (rounded > OUT_MAX) begin
                req_data = OUT_MAX[pOUT_WIDTH-1:0];
                req_sat  = 1'b1;
            end else if (rounded < OUT_MIN) begin
                req_data = OUT_MIN[pOUT_WIDTH-1:0];
                req_sat  = 1'b1;
            end
        end
    end

    // Stage register: holds the converted beat for exactly one cycle
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_last_q  <= 1'b0;
            stage_sat_q   <= 1'b0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                stage_data_q <= req_data;
                stage_last_q <= s_tlast;
                stage_sat_q  <= req_sat;
            end
        end
    end

    // Frame FSM with configuration capture and per-frame statistics
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q       <= S_IDLE;
            cfg_shift_q   <= '0;
            cfg_sat_en_q  <= 1'b0;
            beat_work_q   <= '0;
            sat_work_q    <= '0;
            frame_beats_q <= '0;
            sat_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Clamp events are counted as the flagged beat leaves the stage
            if (stage_valid_q && stage_sat_q && (sat_work_q != 16'hFFFF)) begin
                sat_work_q <= sat_work_q + 16'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cfg_shift_q  <= cfg_shift;
                        cfg_sat_en_q <= cfg_sat_en;
                        beat_work_q  <= 16'd1;
                        sat_work_q   <= '0;
                        state_q      <= s_tlast ? S_FLUSH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (beat_work_q != 16'hFFFF) begin
                            beat_work_q <= beat_work_q + 16'd1;
                        end
                        if (s_tlast) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (drain_done) begin
                        state_q       <= S_IDLE;
                        frame_done_q  <= 1'b1;
                        frame_beats_q <= beat_work_q;
                        sat_cnt_q     <= sat_work_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    fir_sync_fifo #(
        .pWIDTH (pOUT_WIDTH + 1),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk   (axis_clk),
        .srst  (axis_rst),
        .push  (stage_valid_q),
        .din   ({stage_last_q, stage_data_q}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m_tvalid    = fifo_valid;
    assign m_tdata     = fifo_dout[pOUT_WIDTH-1:0];
    assign m_tlast     = fifo_dout[pOUT_WIDTH];
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = frame_done_q;
    assign frame_beats = frame_beats_q;
    assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: rounding, saturation, backpressure,
// frame end handling, latency and mid-frame reset.
module tb_fir_out_requant;

    logic        clk;
    logic        axis_rst;
    logic [4:0]  cfg_shift;
    logic        cfg_sat_en;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_beats;
    logic [15:0] sat_cnt;

    int errors = 0;
    int checks = 0;

    fir_out_requant dut (
        .axis_clk    (clk),
        .axis_rst    (axis_rst),
        .cfg_shift   (cfg_shift),
        .cfg_sat_en  (cfg_sat_en),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_beats (frame_beats),
        .sat_cnt     (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat from a negedge; returns at the negedge after acceptance
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", {31'b0, s_tready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        $display("send data=%08h last=%0d", d, l);
    endtask

    // Pop one output beat and compare it
    task automatic recv(input logic [15:0] d, input logic l, input string tag);
        int n;
        m_tready = 1'b1;
        n = 0;
        while (!m_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'b0, m_tvalid}, 32'd1);
        chk({tag, "_data"}, {16'b0, m_tdata}, {16'b0, d});
        chk({tag, "_last"}, {31'b0, m_tlast}, {31'b0, l});
        $display("recv %s data=%04h last=%0d", tag, m_tdata, m_tlast);
        @(posedge clk);
        @(negedge clk);
        m_tready = 1'b0;
    endtask

    // Wait for the frame_done pulse and compare the frame statistics
    task automatic wait_done(input logic [15:0] beats, input logic [15:0] sats, input string tag);
        int n;
        n = 0;
        while (!frame_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'b0, frame_done}, 32'd1);
        chk({tag, "_beats"}, {16'b0, frame_beats}, {16'b0, beats});
        chk({tag, "_sat"}, {16'b0, sat_cnt}, {16'b0, sats});
        $display("frame %s beats=%0d sat=%0d", tag, frame_beats, sat_cnt);
        @(negedge clk);
        chk({tag, "_pulse1"}, {31'b0, frame_done}, 32'd0);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    int          acc;
    int          got;
    int          nwait;
    int          bad_ready;
    int          pulses;
    logic        took;
    logic [15:0] fe_exp [3];

    initial begin
        axis_rst   = 1'b1;
        cfg_shift  = 5'd0;
        cfg_sat_en = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_s_tready", {31'b0, s_tready}, 32'd0);
        chk("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_m_tdata", {16'b0, m_tdata}, 32'd0);
        chk("rst_m_tlast", {31'b0, m_tlast}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_frame_beats", {16'b0, frame_beats}, 32'd0);
        chk("rst_sat_cnt", {16'b0, sat_cnt}, 32'd0);
        axis_rst = 1'b0;
        @(negedge clk);
        chk("idle_s_tready", {31'b0, s_tready}, 32'd1);

        // Rounding with shift=4; cfg changed mid-frame must be ignored
        cfg_shift  = 5'd4;
        cfg_sat_en = 1'b1;
        send(32'h0000_0128, 1'b0);
        chk("rnd_busy", {31'b0, busy}, 32'd1);
        cfg_shift  = 5'd0;
        cfg_sat_en = 1'b0;
        send(32'hFFFF_FFE8, 1'b0);
        send(32'hFFFF_FFF8, 1'b1);
        chk("rnd_flush_ready", {31'b0, s_tready}, 32'd0);
        recv(16'h0013, 1'b0, "rnd0");
        recv(16'hFFFF, 1'b0, "rnd1");
        recv(16'h0000, 1'b1, "rnd2");
        wait_done(16'd3, 16'd0, "rnd");

        // Saturation
        cfg_shift  = 5'd0;
        cfg_sat_en = 1'b1;
        send(32'h0010_0000, 1'b1);
        recv(16'h7FFF, 1'b1, "satpos");
        wait_done(16'd1, 16'd1, "satpos");
        cfg_sat_en = 1'b0;
        send(32'h0010_0000, 1'b1);
        recv(16'h0000, 1'b1, "nosat");
        wait_done(16'd1, 16'd0, "nosat");
        cfg_sat_en = 1'b1;
        send(32'h8000_0000, 1'b1);
        recv(16'h8000, 1'b1, "satneg");
        wait_done(16'd1, 16'd1, "satneg");

        // Backpressure: 6 beats offered, only 4 fit
        cfg_shift  = 5'd0;
        cfg_sat_en = 1'b1;
        m_tready   = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            s_tvalid = (acc < 6);
            s_tdata  = 32'(acc + 1);
            s_tlast  = (acc == 5);
            took     = s_tvalid && s_tready;
            @(posedge clk);
            @(negedge clk);
            if (took) acc++;
        end
        $display("backpressure accepts=%0d", acc);
        chk("bp_accepts", 32'(acc), 32'd4);
        chk("bp_ready_low", {31'b0, s_tready}, 32'd0);
        chk("bp_head_valid", {31'b0, m_tvalid}, 32'd1);
        chk("bp_head_data", {16'b0, m_tdata}, 32'd1);
        fork
            begin
                for (int i = 4; i < 6; i++) send(32'(i + 1), i == 5);
            end
            begin
                got = 0;
                nwait = 0;
                m_tready = 1'b1;
                while (got < 6 && nwait < 100) begin
                    if (m_tvalid) begin
                        chk("bp_data", {16'b0, m_tdata}, 32'(got + 1));
                        chk("bp_last", {31'b0, m_tlast}, {31'b0, got == 5});
                        $display("recv bp data=%04h last=%0d", m_tdata, m_tlast);
                        got++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    nwait++;
                end
                m_tready = 1'b0;
                chk("bp_count", 32'(got), 32'd6);
            end
        join
        wait_done(16'd6, 16'd0, "bp");

        // Frame end with m_tready toggling 1,0,1
        cfg_shift  = 5'd1;
        cfg_sat_en = 1'b1;
        m_tready   = 1'b0;
        fe_exp[0] = 16'h0002;
        fe_exp[1] = 16'h0003;
        fe_exp[2] = 16'hFFFF;
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'hFFFF_FFFD, 1'b1);
        chk("fe_flush_ready", {31'b0, s_tready}, 32'd0);
        chk("fe_busy", {31'b0, busy}, 32'd1);
        cfg_shift = 5'd2;
        got = 0;
        bad_ready = 0;
        pulses = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            m_tready = (c % 2 == 0);
            if (s_tready) bad_ready++;
            if (frame_done) pulses++;
            if (m_tvalid && m_tready) begin
                chk("fe_data", {16'b0, m_tdata}, {16'b0, fe_exp[got]});
                chk("fe_last", {31'b0, m_tlast}, {31'b0, got == 2});
                $display("recv fe data=%04h last=%0d", m_tdata, m_tlast);
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        m_tready = 1'b0;
        chk("fe_count", 32'(got), 32'd3);
        for (int c = 0; c < 6; c++) begin
            if (s_tready && busy) bad_ready++;
            if (frame_done) begin
                pulses++;
                chk("fe_beats", {16'b0, frame_beats}, 32'd3);
                chk("fe_sat", {16'b0, sat_cnt}, 32'd0);
            end
            @(negedge clk);
        end
        chk("fe_ready_in_flush", 32'(bad_ready), 32'd0);
        chk("fe_done_pulses", 32'(pulses), 32'd1);
        send(32'h0000_0010, 1'b1);
        recv(16'h0004, 1'b1, "fe_new");
        wait_done(16'd1, 16'd0, "fe_new");

        // Latency: m_tvalid rises two edges after acceptance
        cfg_shift  = 5'd0;
        cfg_sat_en = 1'b1;
        m_tready   = 1'b1;
        send(32'h0000_0055, 1'b1);
        chk("lat_k1", {31'b0, m_tvalid}, 32'd0);
        @(negedge clk);
        chk("lat_k2", {31'b0, m_tvalid}, 32'd0);
        @(negedge clk);
        chk("lat_k3", {31'b0, m_tvalid}, 32'd1);
        chk("lat_data", {16'b0, m_tdata}, 32'h55);
        $display("recv lat data=%04h last=%0d", m_tdata, m_tlast);
        wait_done(16'd1, 16'd0, "lat");
        m_tready = 1'b0;

        // Reset in the middle of a frame
        send(32'h0000_0011, 1'b0);
        send(32'h0000_0022, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mr_fifo_full", {31'b0, m_tvalid}, 32'd1);
        axis_rst = 1'b1;
        @(negedge clk);
        chk("mr_m_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("mr_s_tready", {31'b0, s_tready}, 32'd0);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_done", {31'b0, frame_done}, 32'd0);
        chk("mr_beats", {16'b0, frame_beats}, 32'd0);
        @(negedge clk);
        chk("mr_done2", {31'b0, frame_done}, 32'd0);
        axis_rst = 1'b0;
        @(negedge clk);
        chk("mr_done3", {31'b0, frame_done}, 32'd0);
        send(32'h0000_0033, 1'b1);
        recv(16'h0033, 1'b1, "mr_new");
        wait_done(16'd1, 16'd0, "mr_new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
